// File: rtl/adxl345_sampler_if.sv
// Stream bundle between the ADXL345 sampler, its spi_master command/response
// ports and the downstream sample consumer.
interface adxl345_sampler_if;
    // Every channel is valid/ready: a word transfers on a rising sys_clk edge
    // where valid && ready are both high; the source holds data stable while
    // valid is high and never withdraws valid before the transfer.
    logic [15:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [15:0] rsp_tdata;
    logic        rsp_tvalid;
    logic        rsp_tready;
    logic [15:0] sample_tdata;
    logic [1:0]  sample_tuser;
    logic        sample_tlast;
    logic        sample_tvalid;
    logic        sample_tready;

    modport master (
        output cmd_tdata, cmd_tvalid,
        input  cmd_tready,
        input  rsp_tdata, rsp_tvalid,
        output rsp_tready,
        output sample_tdata, sample_tuser, sample_tlast, sample_tvalid,
        input  sample_tready
    );

    modport slave (
        input  cmd_tdata, cmd_tvalid,
        output cmd_tready,
        output rsp_tdata, rsp_tvalid,
        input  rsp_tready,
        input  sample_tdata, sample_tuser, sample_tlast, sample_tvalid,
        output sample_tready
    );
endinterface

// File: rtl/adxl345_sampler.sv
// ADXL345 controller: DEVID check with retry, register init, then periodic
// multi-axis sampling through a 16-bit spi_master onto an AXI-stream.
module adxl345_sampler #(
    parameter int unsigned NUM_AXES        = 3,
    parameter int unsigned SAMPLE_PERIOD   = 100000,
    parameter logic [7:0]  DEVID_EXPECTED  = 8'hE5,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h00,
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic              sys_clk,
    input  logic              reset,
    adxl345_sampler_if.master bus,
    output logic              configured,
    output logic              config_error,
    output logic [15:0]       missed_frames,
    output logic [3:0]        state_dbg
);
    localparam logic [31:0] PERIOD_LAST  = 32'(SAMPLE_PERIOD - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RETRY_LAST   = 32'(MAX_RETRIES - 1);
    localparam logic [1:0]  AXIS_LAST    = 2'(NUM_AXES - 1);
    // D6 selects 3-wire SPI; the bus is wired 4-wire, so it is always cleared.
    localparam logic [7:0]  FMT_BYTE     = DATA_FORMAT_VAL & 8'hBF;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_DEVID, S_CHK_DEVID, S_WR_FMT, S_WR_FMT_RSP, S_WR_BW,
        S_WR_BW_RSP, S_WR_PWR, S_WR_PWR_RSP, S_RUN, S_RD_LO, S_RD_LO_RSP,
        S_RD_HI, S_RD_HI_RSP, S_SAMPLE, S_FAILED
    } state_t;

    state_t      state, state_next;
    logic [31:0] timeout_cnt, retry_cnt, period_cnt;
    logic [1:0]  axis;
    logic [7:0]  lo_q, hi_q;
    logic        wait_hs, run_active, period_wrap, axis_last;
    logic [5:0]  axis_off;
    logic        rsp_hi_unused;

    function automatic logic [15:0] spi_cmd(input logic rd, input logic [5:0] addr,
                                            input logic [7:0] data);
        return {rd, 1'b0, addr, data};
    endfunction

    assign axis_off      = {3'b000, axis, 1'b0};
    assign axis_last     = (axis == AXIS_LAST);
    assign run_active    = configured && (state != S_FAILED);
    assign period_wrap   = run_active && (period_cnt == PERIOD_LAST);
    assign state_dbg     = state;
    assign rsp_hi_unused = ^bus.rsp_tdata[15:8];

    assign bus.sample_tdata = {hi_q, lo_q};
    assign bus.sample_tuser = axis;
    assign bus.sample_tlast = (state == S_SAMPLE) && axis_last;

    always_comb begin
        state_next        = state;
        bus.cmd_tdata     = '0;
        bus.cmd_tvalid    = 1'b0;
        bus.rsp_tready    = 1'b0;
        bus.sample_tvalid = 1'b0;
        wait_hs           = 1'b0;
        case (state)
            S_IDLE: state_next = S_RD_DEVID;
            S_RD_DEVID, S_WR_FMT, S_WR_BW, S_WR_PWR, S_RD_LO, S_RD_HI: begin
                wait_hs        = 1'b1;
                bus.cmd_tvalid = 1'b1;
                case (state)
                    S_RD_DEVID: bus.cmd_tdata = spi_cmd(1'b1, 6'h00, 8'h00);
                    S_WR_FMT:   bus.cmd_tdata = spi_cmd(1'b0, 6'h31, FMT_BYTE);
                    S_WR_BW:    bus.cmd_tdata = spi_cmd(1'b0, 6'h2C, BW_RATE_VAL);
                    S_WR_PWR:   bus.cmd_tdata = spi_cmd(1'b0, 6'h2D, 8'h08);
                    S_RD_LO:    bus.cmd_tdata = spi_cmd(1'b1, 6'h32 + axis_off, 8'h00);
                    default:    bus.cmd_tdata = spi_cmd(1'b1, 6'h33 + axis_off, 8'h00);
                endcase
                if (bus.cmd_tready) state_next = state_t'(state + 4'd1);
            end
            S_CHK_DEVID: begin
                wait_hs        = 1'b1;
                bus.rsp_tready = 1'b1;
                if (bus.rsp_tvalid) begin
                    if (bus.rsp_tdata[7:0] == DEVID_EXPECTED) state_next = S_WR_FMT;
                    else if (retry_cnt == RETRY_LAST)         state_next = S_FAILED;
                    else                                      state_next = S_RD_DEVID;
                end
            end
            S_WR_FMT_RSP, S_WR_BW_RSP, S_WR_PWR_RSP, S_RD_LO_RSP, S_RD_HI_RSP: begin
                wait_hs        = 1'b1;
                bus.rsp_tready = 1'b1;
                if (bus.rsp_tvalid) state_next = state_t'(state + 4'd1);
            end
            S_RUN: if (period_wrap) state_next = S_RD_LO;
            S_SAMPLE: begin
                bus.sample_tvalid = 1'b1;
                if (bus.sample_tready) state_next = axis_last ? S_RUN : S_RD_LO;
            end
            default: state_next = S_FAILED;
        endcase
        // Only SPI handshakes are timed; sample_tready stalls never are.
        if (wait_hs && (state_next == state) && (timeout_cnt == TIMEOUT_LAST))
            state_next = S_FAILED;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state         <= S_IDLE;
            timeout_cnt   <= '0;
            retry_cnt     <= '0;
            period_cnt    <= '0;
            axis          <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            configured    <= 1'b0;
            config_error  <= 1'b0;
            missed_frames <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) timeout_cnt <= '0;
            else if (wait_hs)        timeout_cnt <= timeout_cnt + 32'd1;
            if (state == S_CHK_DEVID && bus.rsp_tvalid && bus.rsp_tdata[7:0] != DEVID_EXPECTED)
                retry_cnt <= retry_cnt + 32'd1;
            if (state == S_WR_PWR_RSP && state_next == S_RUN) configured <= 1'b1;
            if (state_next == S_FAILED && state != S_FAILED) config_error <= 1'b1;
            if (run_active) period_cnt <= period_wrap ? '0 : period_cnt + 32'd1;
            // A frame start that lands on a busy frame is dropped, not queued.
            if (period_wrap && state != S_RUN && missed_frames != 16'hFFFF)
                missed_frames <= missed_frames + 16'd1;
            if (state == S_RD_LO_RSP && bus.rsp_tvalid) lo_q <= bus.rsp_tdata[7:0];
            if (state == S_RD_HI_RSP && bus.rsp_tvalid) hi_q <= bus.rsp_tdata[7:0];
            if (state == S_SAMPLE && bus.sample_tready) axis <= axis_last ? 2'd0 : axis + 2'd1;
        end
    end
endmodule

// File: tb/tb_adxl345_sampler.sv
// Bench for adxl345_sampler: behavioural spi_master/ADXL345 model, frame
// scoreboard and directed init, retry, timeout, overrun and reset sequences.
module tb_adxl345_sampler;
    localparam int SP = 200;
    localparam int TO = 100;

    logic        sys_clk;
    logic        reset;
    logic        configured, config_error;
    logic [15:0] missed_frames;
    logic [3:0]  state_dbg;

    adxl345_sampler_if bus();

    adxl345_sampler #(
        .NUM_AXES(3), .SAMPLE_PERIOD(SP), .DEVID_EXPECTED(8'hE5),
        .DATA_FORMAT_VAL(8'h4B), .BW_RATE_VAL(8'h0A), .MAX_RETRIES(3),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .bus(bus.master),
        .configured(configured), .config_error(config_error),
        .missed_frames(missed_frames), .state_dbg(state_dbg)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SPI slave model: register file, DEVID answer sequence, command log.
    bit          model_stuck = 1'b0;
    logic [7:0]  devid_q[$];
    logic [7:0]  devid_default = 8'hE5;
    logic [7:0]  reg_file[64];
    logic [15:0] cmd_log[$];

    initial begin
        logic        cmd_hs, rsp_hs, rst_s;
        logic [15:0] cmd_w;
        logic [7:0]  d;
        bus.cmd_tready = 1'b0;
        bus.rsp_tvalid = 1'b0;
        bus.rsp_tdata  = '0;
        forever begin
            @(negedge sys_clk);
            cmd_hs = bus.cmd_tvalid && bus.cmd_tready;
            rsp_hs = bus.rsp_tvalid && bus.rsp_tready;
            cmd_w  = bus.cmd_tdata;
            rst_s  = reset;
            @(posedge sys_clk);
            #1;
            if (rst_s) begin
                bus.rsp_tvalid = 1'b0;
                bus.rsp_tdata  = '0;
            end else begin
                if (rsp_hs) bus.rsp_tvalid = 1'b0;
                if (cmd_hs) begin
                    cmd_log.push_back(cmd_w);
                    d = 8'h00;
                    if (cmd_w[15]) begin
                        if (cmd_w[13:8] != 6'h00)   d = reg_file[cmd_w[13:8]];
                        else if (devid_q.size() > 0) d = devid_q.pop_front();
                        else                         d = devid_default;
                    end
                    bus.rsp_tdata  = {8'h5A, d};
                    bus.rsp_tvalid = 1'b1;
                end
            end
            bus.cmd_tready = !model_stuck;
        end
    end

    // Scoreboard: {tdata, tuser, tlast}; samples arriving with an empty queue
    // belong to frames the current test does not track.
    logic [18:0] exp_q[$];
    int last_tlast_cyc = 0;
    int prev_tlast_cyc = 0;

    always @(negedge sys_clk) begin
        if (!reset && bus.sample_tvalid && bus.sample_tready) begin
            if (bus.sample_tlast) begin
                prev_tlast_cyc = last_tlast_cyc;
                last_tlast_cyc = cyc;
            end
            if (exp_q.size() > 0)
                check("sample", {13'd0, bus.sample_tdata, bus.sample_tuser, bus.sample_tlast},
                      {13'd0, exp_q.pop_front()});
        end
    end

    typedef struct {
        logic [7:0]  x_lo, x_hi, y_lo, y_hi, z_lo, z_hi;
        logic [15:0] exp_x, exp_y, exp_z;
    } vec_t;
    vec_t vecs[3];

    task automatic apply_reset();
        @(posedge sys_clk);
        #1 reset = 1'b1;
        @(posedge sys_clk);
        #1 reset = 1'b0;
        @(negedge sys_clk);
        cmd_log.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_tvalid"}, bus.cmd_tvalid, 0);
        check({tag, "_cmd_tdata"}, bus.cmd_tdata, 0);
        check({tag, "_rsp_tready"}, bus.rsp_tready, 0);
        check({tag, "_sample_tvalid"}, bus.sample_tvalid, 0);
        check({tag, "_flags"}, {configured, config_error}, 0);
        check({tag, "_missed"}, missed_frames, 0);
    endtask

    task automatic wait_cfg(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (configured || config_error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_regs(input vec_t v);
        reg_file[6'h32] = v.x_lo; reg_file[6'h33] = v.x_hi;
        reg_file[6'h34] = v.y_lo; reg_file[6'h35] = v.y_hi;
        reg_file[6'h36] = v.z_lo; reg_file[6'h37] = v.z_hi;
    endtask

    task automatic push_frame(input vec_t v);
        exp_q.push_back({v.exp_x, 2'd0, 1'b0});
        exp_q.push_back({v.exp_y, 2'd1, 1'b0});
        exp_q.push_back({v.exp_z, 2'd2, 1'b1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt;
        vecs[0] = '{8'h38, 8'hFF, 8'h10, 8'h00, 8'h00, 8'h01, 16'hFF38, 16'h0010, 16'h0100};
        vecs[1] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h00, 8'h00, 16'h7FFF, 16'h8000, 16'h0000};
        vecs[2] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 16'h1234, 16'hABCD, 16'h00FF};
        foreach (reg_file[i]) reg_file[i] = 8'h00;
        reset = 1'b1;
        bus.sample_tready = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check_outputs_zero("reset");

        // Clean init: DEVID read then the three register writes.
        #1 reset = 1'b0;
        wait_cfg(200, ok);
        check("init_wait", ok, 1);
        check("init_flags", {configured, config_error}, 2'b10);
        check("init_cmd_count", cmd_log.size(), 4);
        check("init_cmd0", cmd_log[0], 16'h8000);
        check("init_cmd1", cmd_log[1], 16'h310B);
        check("init_cmd2", cmd_log[2], 16'h2C0A);
        check("init_cmd3", cmd_log[3], 16'h2D08);

        for (int r = 0; r < 3; r++) begin
            load_regs(vecs[r]);
            push_frame(vecs[r]);
            wait_drain(3 * SP, ok);
            check("frame_drain", ok, 1);
            if (r > 0) check("frame_period", last_tlast_cyc - prev_tlast_cyc, SP);
        end
        check("missed_none", missed_frames, 0);

        // Output stall across three frame starts, then recovery.
        @(posedge sys_clk);
        #1 bus.sample_tready = 1'b0;
        load_regs(vecs[0]);
        push_frame(vecs[0]);
        push_frame(vecs[0]);
        cnt = 0;
        while (!bus.sample_tvalid && cnt < 2 * SP) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("stall_valid_seen", bus.sample_tvalid, 1);
        repeat (3 * SP + 20) @(posedge sys_clk);
        #1 bus.sample_tready = 1'b1;
        wait_drain(3 * SP, ok);
        check("stall_drain", ok, 1);
        check("missed_three", missed_frames, 3);

        // DEVID retry: two wrong answers then the right one.
        devid_q = '{8'h00, 8'h00, 8'hE5};
        apply_reset();
        wait_cfg(300, ok);
        check("retry_flags", {configured, config_error}, 2'b10);
        check("retry_cmd_count", cmd_log.size(), 6);
        check("retry_cmd2", cmd_log[2], 16'h8000);
        check("retry_cmd3", cmd_log[3], 16'h310B);

        // DEVID never matches.
        devid_default = 8'h00;
        apply_reset();
        wait_cfg(300, ok);
        repeat (50) @(negedge sys_clk);
        check("devid_fail_flags", {configured, config_error}, 2'b01);
        check("devid_fail_cmds", cmd_log.size(), 3);
        check("devid_fail_idle", {bus.cmd_tvalid, bus.rsp_tready, bus.sample_tvalid}, 0);

        // cmd_tready stuck low: exactly TO cycles of cmd_tvalid before failure.
        devid_default = 8'hE5;
        model_stuck = 1'b1;
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            @(negedge sys_clk);
            if (config_error) break;
            if (bus.cmd_tvalid) cnt++;
        end
        check("timeout_cycles", cnt, TO);
        check("timeout_error", config_error, 1);
        check("timeout_cmd_drop", bus.cmd_tvalid, 0);
        model_stuck = 1'b0;

        // One-cycle reset while a frame read is in flight.
        apply_reset();
        wait_cfg(300, ok);
        check("midreset_cfg", configured, 1);
        cnt = 0;
        while (!bus.rsp_tready && cnt < 2 * SP) begin
            @(negedge sys_clk);
            cnt++;
        end
        check("midreset_inflight", bus.rsp_tready, 1);
        apply_reset();
        check_outputs_zero("midreset");
        wait_cfg(300, ok);
        check("midreset_reinit", {configured, config_error}, 2'b10);
        check("midreset_first_cmd", cmd_log[0], 16'h8000);
        load_regs(vecs[1]);
        push_frame(vecs[1]);
        wait_drain(3 * SP, ok);
        check("midreset_frame", ok, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
